// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Brief    : Raster position / sync bundle shared between the timing
//             generator (master) and the pixel/object controllers (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
   logic       pix_en;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       hSync;
   logic       vSync;
   logic       bright;
   logic       line_tick;
   logic       frame_tick;

   // Timing generator drives the whole bundle
   modport master (
      output pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick
   );

   // Consumers only observe it
   modport slave (
      input  pix_en, hCount, vCount, hSync, vSync, bright, line_tick, frame_tick
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : Pixel-rate divider plus horizontal/vertical raster counters with
//             sync, active-region and line/frame strobe decode (640x480@60 by
//             default).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int DIV      = 4,     // clk cycles per pixel, 1..16
   parameter int H_SYNC   = 96,    // hSync width in pixels
   parameter int H_BP     = 48,    // horizontal back porch
   parameter int H_ACT    = 640,   // active pixels per line
   parameter int H_TOTAL  = 800,   // pixels per line (<= 1024)
   parameter int V_SYNC   = 2,     // vSync width in lines
   parameter int V_BP     = 33,    // vertical back porch
   parameter int V_ACT    = 480,   // active lines
   parameter int V_TOTAL  = 525,   // lines per frame (<= 1024)
   parameter bit SYNC_POL = 1'b0   // asserted sync level
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   vga_timing_gen_if.master   vga
);

   // Divider width: at least one bit so DIV=1 still has a legal (constant) counter
   localparam int C_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [C_DIV_W-1:0] c_div_last  = C_DIV_W'(DIV - 1);
   localparam logic [9:0]         c_h_last    = 10'(H_TOTAL - 1);
   localparam logic [9:0]         c_v_last    = 10'(V_TOTAL - 1);
   localparam logic [9:0]         c_h_sync_w  = 10'(H_SYNC);
   localparam logic [9:0]         c_v_sync_w  = 10'(V_SYNC);
   localparam logic [9:0]         c_h_act_lo  = 10'(H_SYNC + H_BP);
   localparam logic [9:0]         c_h_act_hi  = 10'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [9:0]         c_v_act_lo  = 10'(V_SYNC + V_BP);
   localparam logic [9:0]         c_v_act_hi  = 10'(V_SYNC + V_BP + V_ACT - 1);

   logic [C_DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]         h_cnt_q,   h_cnt_d;
   logic [9:0]         v_cnt_q,   v_cnt_d;

   logic w_pix_en;
   logic w_h_last;
   logic w_v_last;
   logic w_hsync;
   logic w_vsync;
   logic w_bright;
   logic w_line_tick;
   logic w_frame_tick;

   // Pixel strobe: last phase of the divider, forced low while reset is held
   // (with DIV=1 the divider sits at its last phase permanently)
   always_comb begin
      w_pix_en = 1'b0;
      if (div_cnt_q == c_div_last) begin
         w_pix_en = rst_n;
      end
   end

   // Divider next state: count 0..DIV-1 and wrap
   always_comb begin
      div_cnt_d = div_cnt_q + C_DIV_W'(1);
      if (div_cnt_q == c_div_last) begin
         div_cnt_d = '0;
      end
   end

   // Raster next state: advance one pixel per strobe, wrap line then frame
   always_comb begin
      w_h_last = (h_cnt_q == c_h_last);
      w_v_last = (v_cnt_q == c_v_last);
      h_cnt_d  = h_cnt_q;
      v_cnt_d  = v_cnt_q;
      if (w_pix_en) begin
         if (w_h_last) begin
            h_cnt_d = '0;
            if (w_v_last) begin
               v_cnt_d = '0;
            end else begin
               v_cnt_d = v_cnt_q + 10'd1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   // State registers; reset drops everything to the top-left corner at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   // Decode sync, active region and strobes straight from the registered counts
   always_comb begin
      w_hsync      = ~SYNC_POL;
      w_vsync      = ~SYNC_POL;
      w_bright     = 1'b0;
      w_line_tick  = 1'b0;
      w_frame_tick = 1'b0;
      if (h_cnt_q < c_h_sync_w) begin
         w_hsync = SYNC_POL;
      end
      if (v_cnt_q < c_v_sync_w) begin
         w_vsync = SYNC_POL;
      end
      if ((h_cnt_q >= c_h_act_lo) && (h_cnt_q <= c_h_act_hi) &&
          (v_cnt_q >= c_v_act_lo) && (v_cnt_q <= c_v_act_hi)) begin
         w_bright = 1'b1;
      end
      if (w_pix_en && w_h_last) begin
         w_line_tick  = 1'b1;
         w_frame_tick = w_v_last;
      end
   end

   assign vga.pix_en     = w_pix_en;
   assign vga.hCount     = h_cnt_q;
   assign vga.vCount     = v_cnt_q;
   assign vga.hSync      = w_hsync;
   assign vga.vSync      = w_vsync;
   assign vga.bright     = w_bright;
   assign vga.line_tick  = w_line_tick;
   assign vga.frame_tick = w_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Bench for vga_timing_gen. Three instances: a scaled-down
//             geometry with DIV=4, a DIV=1 / positive-sync geometry, and the
//             default 640x480 configuration. Raster outputs are predicted from
//             the number of clock edges since reset release.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   logic       clk   = 1'b0;
   logic [2:0] rst_v = 3'b000;
   int         cyc   = 0;

   always #5 clk = ~clk;

   // Free-running cycle counter used for period measurements
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();
   vga_timing_gen_if if_c ();

   vga_timing_gen #(
      .DIV(4), .H_SYNC(4), .H_BP(3), .H_ACT(10), .H_TOTAL(20),
      .V_SYNC(2), .V_BP(3), .V_ACT(6), .V_TOTAL(13), .SYNC_POL(1'b0)
   ) u_a (.clk(clk), .rst_n(rst_v[0]), .vga(if_a));

   vga_timing_gen #(
      .DIV(1), .H_SYNC(3), .H_BP(2), .H_ACT(8), .H_TOTAL(16),
      .V_SYNC(1), .V_BP(2), .V_ACT(5), .V_TOTAL(10), .SYNC_POL(1'b1)
   ) u_b (.clk(clk), .rst_n(rst_v[1]), .vga(if_b));

   vga_timing_gen u_c (.clk(clk), .rst_n(rst_v[2]), .vga(if_c));

   // Geometry of each instance, index 0=A 1=B 2=C
   int p_div [3] = '{4, 1, 4};
   int p_hs  [3] = '{4, 3, 96};
   int p_hb  [3] = '{3, 2, 48};
   int p_ha  [3] = '{10, 8, 640};
   int p_ht  [3] = '{20, 16, 800};
   int p_vs  [3] = '{2, 1, 2};
   int p_vb  [3] = '{3, 2, 33};
   int p_va  [3] = '{6, 5, 480};
   int p_vt  [3] = '{13, 10, 525};
   bit p_pol [3] = '{1'b0, 1'b1, 1'b0};
   string p_name [3] = '{"A", "B", "C"};

   int n_assert = 0;
   int n_fail   = 0;

   int k       [3];
   int last_lt [3];
   int last_ft [3];
   bit seen_lt [3];
   bit seen_ft [3];
   int br_cnt  [3];
   int hs_cnt  [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic grab(input int d, output logic pe, output logic [9:0] hc, output logic [9:0] vc,
                       output logic hs, output logic vs, output logic br, output logic lt, output logic ft);
      case (d)
         0: begin
            pe = if_a.pix_en; hc = if_a.hCount; vc = if_a.vCount; hs = if_a.hSync;
            vs = if_a.vSync; br = if_a.bright; lt = if_a.line_tick; ft = if_a.frame_tick;
         end
         1: begin
            pe = if_b.pix_en; hc = if_b.hCount; vc = if_b.vCount; hs = if_b.hSync;
            vs = if_b.vSync; br = if_b.bright; lt = if_b.line_tick; ft = if_b.frame_tick;
         end
         default: begin
            pe = if_c.pix_en; hc = if_c.hCount; vc = if_c.vCount; hs = if_c.hSync;
            vs = if_c.vSync; br = if_c.bright; lt = if_c.line_tick; ft = if_c.frame_tick;
         end
      endcase
   endtask

   // Compare all outputs against the raster position implied by k edges since release
   task automatic observe(input int d);
      logic pe, hs, vs, br, lt, ft;
      logic [9:0] hc, vc;
      int n, h, v, act_h0, act_v0;
      bit e_pe, e_hs, e_vs, e_br, e_lt, e_ft;
      string t;
      grab(d, pe, hc, vc, hs, vs, br, lt, ft);
      n      = k[d] / p_div[d];
      h      = n % p_ht[d];
      v      = (n / p_ht[d]) % p_vt[d];
      act_h0 = p_hs[d] + p_hb[d];
      act_v0 = p_vs[d] + p_vb[d];
      e_pe   = (k[d] % p_div[d]) == p_div[d] - 1;
      e_hs   = (h < p_hs[d]) ? p_pol[d] : !p_pol[d];
      e_vs   = (v < p_vs[d]) ? p_pol[d] : !p_pol[d];
      e_br   = (h >= act_h0) && (h < act_h0 + p_ha[d]) && (v >= act_v0) && (v < act_v0 + p_va[d]);
      e_lt   = e_pe && (h == p_ht[d] - 1);
      e_ft   = e_lt && (v == p_vt[d] - 1);
      t = $sformatf("%s k=%0d", p_name[d], k[d]);
      chk({t, " pix_en"},     32'(pe), 32'(e_pe));
      chk({t, " hCount"},     32'(hc), 32'(h));
      chk({t, " vCount"},     32'(vc), 32'(v));
      chk({t, " hSync"},      32'(hs), 32'(e_hs));
      chk({t, " vSync"},      32'(vs), 32'(e_vs));
      chk({t, " bright"},     32'(br), 32'(e_br));
      chk({t, " line_tick"},  32'(lt), 32'(e_lt));
      chk({t, " frame_tick"}, 32'(ft), 32'(e_ft));
      // Whole-line and whole-frame aggregates measured between consecutive ticks
      if (hs === p_pol[d]) hs_cnt[d]++;
      if (br === 1'b1)     br_cnt[d]++;
      if (lt === 1'b1) begin
         if (seen_lt[d]) begin
            chk({t, " line period"}, 32'(cyc - last_lt[d]), 32'(p_ht[d] * p_div[d]));
            chk({t, " hSync width"}, 32'(hs_cnt[d]), 32'(p_hs[d] * p_div[d]));
         end
         seen_lt[d] = 1'b1;
         last_lt[d] = cyc;
         hs_cnt[d]  = 0;
      end
      if (ft === 1'b1) begin
         if (seen_ft[d]) begin
            chk({t, " frame period"}, 32'(cyc - last_ft[d]), 32'(p_ht[d] * p_vt[d] * p_div[d]));
            chk({t, " bright cycles"}, 32'(br_cnt[d]), 32'(p_ha[d] * p_va[d] * p_div[d]));
         end
         seen_ft[d] = 1'b1;
         last_ft[d] = cyc;
         br_cnt[d]  = 0;
      end
   endtask

   // Everything idle and syncs at their asserted level while reset is held
   task automatic reset_check(input int d);
      logic pe, hs, vs, br, lt, ft;
      logic [9:0] hc, vc;
      string t;
      grab(d, pe, hc, vc, hs, vs, br, lt, ft);
      t = {p_name[d], " in reset"};
      chk({t, " pix_en"},     32'(pe), 32'd0);
      chk({t, " hCount"},     32'(hc), 32'd0);
      chk({t, " vCount"},     32'(vc), 32'd0);
      chk({t, " hSync"},      32'(hs), 32'(p_pol[d]));
      chk({t, " vSync"},      32'(vs), 32'(p_pol[d]));
      chk({t, " bright"},     32'(br), 32'd0);
      chk({t, " line_tick"},  32'(lt), 32'd0);
      chk({t, " frame_tick"}, 32'(ft), 32'd0);
   endtask

   task automatic release_rst(input int d);
      @(negedge clk);
      rst_v[d]   = 1'b1;
      k[d]       = 0;
      seen_lt[d] = 1'b0;
      seen_ft[d] = 1'b0;
      br_cnt[d]  = 0;
      hs_cnt[d]  = 0;
      #1;
      observe(d);
   endtask

   task automatic step(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         k[d]++;
         observe(d);
      end
   endtask

   // Assert reset between edges, confirm it acts without a clock, hold, release
   task automatic async_reset(input int d, input int hold);
      #2;
      rst_v[d] = 1'b0;
      #1;
      reset_check(d);
      for (int j = 0; j < hold; j++) begin
         @(posedge clk);
         #1;
         reset_check(d);
      end
      release_rst(d);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         k[d] = 0; last_lt[d] = 0; last_ft[d] = 0; seen_lt[d] = 1'b0;
         seen_ft[d] = 1'b0; br_cnt[d] = 0; hs_cnt[d] = 0;
      end

      // Reset state of all three instances
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) reset_check(d);

      // Default 640x480 geometry: first strobe at edge 4, three full lines
      release_rst(2);
      step(2, 3 * 3200 + 10);
      rst_v[2] = 1'b0;

      // Scaled geometry, DIV=4: two full frames including both wraps
      release_rst(0);
      step(0, 2 * 1040 + 50);

      // Directed mid-frame reset at hCount=12, vCount=7
      async_reset(0, 1);
      step(0, (7 * 20 + 12) * 4);
      async_reset(0, 2);

      // Random mid-frame resets of random length
      for (int r = 0; r < 4; r++) begin
         step(0, int'($urandom_range(50, 1500)));
         async_reset(0, int'($urandom_range(0, 4)));
      end
      step(0, 2 * 1040 + 20);
      rst_v[0] = 1'b0;

      // DIV=1, positive sync: strobe constant, short frames
      release_rst(1);
      step(1, 400);
      for (int r = 0; r < 3; r++) begin
         async_reset(1, int'($urandom_range(0, 3)));
         step(1, int'($urandom_range(20, 200)));
      end
      step(1, 340);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
